// File: rtl/mig_ui_pkg.sv
// Shared constants for the MIG 7-series user (app_*) interface.
// The DDR controller imports the same package, so both sides agree on the
// command encodings and default widths.
package mig_ui_pkg;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  localparam int unsigned MIG_DATA_W = 128;
  localparam int unsigned MIG_ADDR_W = 27;

  // Seed of the optional ready-stall LFSR.
  localparam logic [7:0] MIG_LFSR_SEED = 8'hA5;

  // Calibration sequencing of the responder.
  typedef enum logic {
    StCalib,
    StReady
  } calib_st_e;

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4.
  function automatic logic [7:0] mig_lfsr_next(logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/mig_resp_rd_pipe.sv
// Read-return shift pipeline: valid and data advance one stage per clock, the
// last stage drives the read-return outputs. Asynchronous active-high clear
// drops every in-flight beat.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high clear
//   vld_i   beat entering the pipeline
//   data_i  data of that beat
//   vld_o   beat leaving the pipeline (LATENCY cycles later)
//   data_o  data of the leaving beat
module mig_resp_rd_pipe #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  dat_q [LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q    <= {vld_q[LATENCY-2:0], vld_i};
      dat_q[0] <= data_i;
      for (int i = 1; i < LATENCY; i++) dat_q[i] <= dat_q[i-1];
    end
  end

  assign vld_o  = vld_q[LATENCY-1];
  assign data_o = dat_q[LATENCY-1];

endmodule

// File: rtl/mig_ui_responder.sv
// Behavioural stand-in for the MIG 7-series DDR controller user interface.
// Commands and write data are serviced from an on-chip word array; reads
// return after a fixed latency with no backpressure.
// Ports:
//   ui_clk, rst                     clock, asynchronous active-high reset
//   app_addr/app_cmd/app_en/app_rdy command channel
//   app_wdf_*                       write-data channel (mask bit 1 = keep byte)
//   app_rd_data/_valid/_end         read-return channel
//   init_calib_complete             set CALIB_CYCLES cycles after reset release
// Build option: define MIG_UI_RESPONDER_STALL_EN to add an LFSR that randomly
// withholds both ready outputs, exercising controller backpressure handling.
module mig_ui_responder
  import mig_ui_pkg::*;
#(
  parameter int unsigned ADDR_W         = MIG_ADDR_W,
  parameter int unsigned DATA_W         = MIG_DATA_W,
  parameter int unsigned MEM_WORDS_LOG2 = 10,
  parameter int unsigned CALIB_CYCLES   = 64,
  parameter int unsigned RD_LATENCY     = 4
) (
  input  logic                ui_clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   app_addr,
  input  logic [2:0]          app_cmd,
  input  logic                app_en,
  output logic                app_rdy,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                init_calib_complete
);

  localparam int unsigned Words = 1 << MEM_WORDS_LOG2;
  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned CntW = $clog2(CALIB_CYCLES + 1);

  // Calibration
  calib_st_e       st_q;
  logic [CntW-1:0] cnt_q;
  logic            calibrated;

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      st_q  <= StCalib;
      cnt_q <= '0;
    end else begin
      unique case (st_q)
        StCalib: begin
          if (cnt_q == CntW'(CALIB_CYCLES - 1)) st_q <= StReady;
          else cnt_q <= cnt_q + 1'b1;
        end
        StReady: st_q <= StReady;
      endcase
    end
  end

  assign calibrated          = (st_q == StReady);
  assign init_calib_complete = calibrated;

  // Optional ready stall
  logic stall;
`ifdef MIG_UI_RESPONDER_STALL_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) lfsr_q <= MIG_LFSR_SEED;
    else if (calibrated) lfsr_q <= mig_lfsr_next(lfsr_q);
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Write pairing: one held command, one held data beat
  logic                      pend_q, pend_d;
  logic [MEM_WORDS_LOG2-1:0] pend_idx_q, pend_idx_d;
  logic                      held_q, held_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [NumBytes-1:0]       wmask_q, wmask_d;

  logic [MEM_WORDS_LOG2-1:0] addr_idx, wr_idx;
  logic [DATA_W-1:0]         wr_data;
  logic [NumBytes-1:0]       wr_mask;
  logic                      wr_cmd_acc, rd_acc, wdf_acc, commit;

  assign app_rdy     = calibrated & ~pend_q & ~stall;
  assign app_wdf_rdy = calibrated & ~held_q & ~stall;

  assign addr_idx   = app_addr[3 +: MEM_WORDS_LOG2];
  assign wr_cmd_acc = app_en & app_rdy & (app_cmd == MIG_CMD_WRITE);
  assign rd_acc     = app_en & app_rdy & (app_cmd == MIG_CMD_READ);
  assign wdf_acc    = app_wdf_wren & app_wdf_rdy;
  // Commit as soon as a command and a data beat are each either held or arriving.
  assign commit     = (pend_q | wr_cmd_acc) & (held_q | wdf_acc);
  assign wr_idx     = pend_q ? pend_idx_q : addr_idx;
  assign wr_data    = held_q ? wdata_q : app_wdf_data;
  assign wr_mask    = held_q ? wmask_q : app_wdf_mask;

  always_comb begin
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    held_d     = held_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if (commit) begin
      pend_d = 1'b0;
      held_d = 1'b0;
    end else begin
      if (wr_cmd_acc) begin
        pend_d     = 1'b1;
        pend_idx_d = addr_idx;
      end
      if (wdf_acc) begin
        held_d  = 1'b1;
        wdata_d = app_wdf_data;
        wmask_d = app_wdf_mask;
      end
    end
  end

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      held_q     <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      held_q     <= held_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
    end
  end

  // Memory array (contents survive reset)
  logic [DATA_W-1:0] mem_q [Words];

  always_ff @(posedge ui_clk) begin
    if (commit) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (!wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read sample at the accept edge, then the latency pipeline
  logic              rd_vld_q;
  logic [DATA_W-1:0] rd_dat_q;

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= rd_acc;
      rd_dat_q <= mem_q[addr_idx];
    end
  end

  mig_resp_rd_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk_i  (ui_clk),
    .rst_i  (rst),
    .vld_i  (rd_vld_q),
    .data_i (rd_dat_q),
    .vld_o  (app_rd_data_valid),
    .data_o (app_rd_data)
  );

  assign app_rd_data_end = app_rd_data_valid;

  // Column bits, aliasing bits and wdf_end carry no information here.
  logic unused_in;
  assign unused_in = ^{app_addr[2:0], app_addr[ADDR_W-1:3+MEM_WORDS_LOG2], app_wdf_end};

endmodule

// File: tb/tb_mig_ui_responder.sv
module tb_mig_ui_responder;
  import mig_ui_pkg::*;

  localparam int AW = 27, DW = 128, LOG2 = 10, CAL = 64, LAT = 4;
  localparam int NB = DW / 8, WORDS = 1 << LOG2;

  logic          ui_clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] app_addr = '0;
  logic [2:0]    app_cmd = '0;
  logic          app_en = 1'b0;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data = '0;
  logic [NB-1:0] app_wdf_mask = '0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b0;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;

  always #5 ui_clk = ~ui_clk;

  mig_ui_responder #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .MEM_WORDS_LOG2 (LOG2),
    .CALIB_CYCLES   (CAL),
    .RD_LATENCY     (LAT)
  ) dut (
    .ui_clk              (ui_clk),
    .rst                 (rst),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Free-running cycle count and cycles since reset release.
  longint cyc_n = 0;
  int     cal_cnt = 0;
  always @(posedge ui_clk) cyc_n <= cyc_n + 1;
  always @(posedge ui_clk or posedge rst) begin
    if (rst) cal_cnt <= 0;
    else if (cal_cnt < CAL) cal_cnt <= cal_cnt + 1;
  end

  function automatic bit m_calib();
    return cal_cnt >= CAL;
  endfunction

  // Reference model: word store with per-byte "known" flags, and the single
  // held write command / write beat.
  logic [DW-1:0] mm [WORDS];
  logic [NB-1:0] mk [WORDS];
  bit            m_pend = 0, m_held = 0;
  int            m_idx = 0;
  logic [DW-1:0] m_dat;
  logic [NB-1:0] m_msk;

  typedef struct {
    longint        due;
    logic [DW-1:0] d;
    logic [NB-1:0] k;
  } rd_t;
  rd_t rd_q[$];

  // Stimulus slots: a command and a write beat, each held until accepted.
  bit            c_v = 0;
  logic [2:0]    c_cmd;
  logic [AW-1:0] c_addr;
  bit            d_v = 0;
  logic [DW-1:0] d_dat;
  logic [NB-1:0] d_msk;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [DW-1:0] byte_bits(input logic [NB-1:0] k);
    logic [DW-1:0] r;
    for (int b = 0; b < NB; b++) r[8*b +: 8] = {8{k[b]}};
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever a read beat appears.
  always @(negedge ui_clk) begin
    rd_t e;
    logic [DW-1:0] bm;
    while (rd_q.size() > 0 && rd_q[0].due < cyc_n) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_missing: got no beat expected beat due at cycle %0d", rd_q[0].due);
      void'(rd_q.pop_front());
    end
    check("rd_end", DW'(app_rd_data_end), DW'(app_rd_data_valid));
    if (app_rd_data_valid) begin
      if (rd_q.size() == 0 || rd_q[0].due != cyc_n) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got beat at cycle %0d expected none", cyc_n);
      end else begin
        e  = rd_q.pop_front();
        bm = byte_bits(e.k);
        check("rd_data", app_rd_data & bm, e.d & bm);
      end
    end
    check("calib", DW'(init_calib_complete), DW'(m_calib()));
  end

  // One cycle: present slots, check readies against the model, update model.
  task automatic drive();
    bit exp_r, exp_w, cacc, dacc;
    int idx;
    app_en       = c_v;
    app_cmd      = c_cmd;
    app_addr     = c_addr;
    app_wdf_wren = d_v;
    app_wdf_end  = d_v;
    app_wdf_data = d_dat;
    app_wdf_mask = d_msk;
    #1;
    exp_r = m_calib() && !m_pend;
    exp_w = m_calib() && !m_held;
`ifdef MIG_UI_RESPONDER_STALL_EN
    check("app_rdy_allowed", DW'(app_rdy && !exp_r), '0);
    check("app_wdf_rdy_allowed", DW'(app_wdf_rdy && !exp_w), '0);
`else
    check("app_rdy", DW'(app_rdy), DW'(exp_r));
    check("app_wdf_rdy", DW'(app_wdf_rdy), DW'(exp_w));
`endif
    cacc = c_v && app_rdy;
    dacc = d_v && app_wdf_rdy;
    @(posedge ui_clk);
    #1;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    idx = int'((c_addr / 8) % WORDS);
    if (cacc && c_cmd == MIG_CMD_READ) rd_q.push_back('{cyc_n + LAT, mm[idx], mk[idx]});
    if (cacc && c_cmd == MIG_CMD_WRITE) begin
      m_pend = 1;
      m_idx  = idx;
    end
    if (dacc) begin
      m_held = 1;
      m_dat  = d_dat;
      m_msk  = d_msk;
    end
    if (m_pend && m_held) begin
      for (int b = 0; b < NB; b++) begin
        if (!m_msk[b]) begin
          mm[m_idx][8*b +: 8] = m_dat[8*b +: 8];
          mk[m_idx][b] = 1'b1;
        end
      end
      m_pend = 0;
      m_held = 0;
    end
    if (cacc) c_v = 0;
    if (dacc) d_v = 0;
    @(negedge ui_clk);
  endtask

  task automatic run_done();
    int n = 0;
    while ((c_v || d_v) && n < 200) begin
      drive();
      n++;
    end
    n_tests++;
    if (c_v || d_v) begin
      n_fail++;
      $display("FAIL handshake_timeout: got cmd=%0b data=%0b pending expected both accepted", c_v, d_v);
      c_v = 0;
      d_v = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive();
  endtask

  task automatic set_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr);
    c_v = 1; c_cmd = cmd; c_addr = addr;
  endtask

  task automatic set_data(input logic [DW-1:0] d, input logic [NB-1:0] m);
    d_v = 1; d_dat = d; d_msk = m;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  w;
    for (int i = 0; i < WORDS; i++) mk[i] = '0;

    // Reset values
    repeat (3) @(negedge ui_clk);
    check("rst_app_rdy", DW'(app_rdy), '0);
    check("rst_wdf_rdy", DW'(app_wdf_rdy), '0);
    check("rst_rd_valid", DW'(app_rd_data_valid), '0);
    check("rst_rd_end", DW'(app_rd_data_end), '0);
    check("rst_rd_data", app_rd_data, '0);
    check("rst_calib", DW'(init_calib_complete), '0);
    rst = 1'b0;
    idle(CAL + 4);

    // Command and data in the same cycle, immediate readback
    set_cmd(MIG_CMD_WRITE, 27'h20);
    set_data(128'h0123456789ABCDEF0123456789ABCDEF, '0);
    run_done();
    set_cmd(MIG_CMD_READ, 27'h20);
    run_done();
    idle(6);

    // Data first, command three cycles later, byte mask
    set_cmd(MIG_CMD_WRITE, 27'h0);
    set_data('0, '0);
    run_done();
    set_data({DW{1'b1}}, 16'h00FF);
    run_done();
    idle(3);
    set_cmd(MIG_CMD_WRITE, 27'h0);
    run_done();
    set_cmd(MIG_CMD_READ, 27'h0);
    run_done();
    idle(6);

    // Command first, data withheld while a read waits
    set_cmd(MIG_CMD_WRITE, 27'h40);
    run_done();
    set_cmd(MIG_CMD_READ, 27'h40);
    repeat (3) drive();
    set_data(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, '0);
    run_done();
    idle(6);

    // Back-to-back reads plus an aliased address
    for (int i = 1; i < 4; i++) begin
      set_cmd(MIG_CMD_WRITE, AW'(i * 8));
      set_data({4{$urandom()}}, '0);
      run_done();
    end
    for (int i = 0; i < 4; i++) begin
      set_cmd(MIG_CMD_READ, AW'(i * 8));
      run_done();
    end
    set_cmd(MIG_CMD_READ, 27'h2000);
    run_done();
    idle(8);

    // Reset with two reads in flight
    set_cmd(MIG_CMD_READ, 27'h20);
    run_done();
    set_cmd(MIG_CMD_READ, 27'h0);
    run_done();
    @(posedge ui_clk);
    #2;
    rst = 1'b1;
    rd_q.delete();
    m_pend = 0;
    m_held = 0;
    #1;
    check("midrst_app_rdy", DW'(app_rdy), '0);
    check("midrst_calib", DW'(init_calib_complete), '0);
    repeat (3) @(negedge ui_clk);
    rst = 1'b0;
    idle(CAL + 4);

    // Randomised traffic over a handful of words with aliasing bits
    repeat (1500) begin
      if (!c_v && $urandom_range(0, 2) == 0) begin
        r = $urandom();
        w = 4'($urandom_range(0, 15));
        c_addr = {r[26:13], 6'b0, w, r[2:0]};
        case ($urandom_range(0, 19)) inside
          [0:8]:   c_cmd = MIG_CMD_WRITE;
          [9:17]:  c_cmd = MIG_CMD_READ;
          default: c_cmd = 3'($urandom_range(2, 7));
        endcase
        c_v = 1;
      end
      if (!d_v && $urandom_range(0, 2) == 0) begin
        set_data({$urandom(), $urandom(), $urandom(), $urandom()},
                 ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom()));
      end
      drive();
    end
    c_v = 0;
    d_v = 0;
    idle(LAT + 6);
    check("scoreboard_drained", DW'(rd_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mig_ui_responder.md
# mig_ui_responder

Behavioural responder for the MIG 7-series user (app_*) interface: accepts read and write commands from a DDR controller and services them from an on-chip memory array. It stands in for the DDR2 memory controller IP in simulation and in DDR-less FPGA builds. It presents identical handshake, calibration and read-return behaviour, so the controller runs unmodified against it.

## Interface
- ADDR_W, 27, width of app_addr
- DATA_W, 128, width of one data beat (BL8 × x16)
- MEM_WORDS_LOG2, 10, log2 of number of DATA_W-bit words stored
- CALIB_CYCLES, 64, cycles from reset release to init_calib_complete
- RD_LATENCY, 4, read accept to read data valid, ≥2
- ui_clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- app_addr  in  ADDR_W  command address in 16-bit column units
- app_cmd  in  3  000 write, 001 read, other values ignored
- app_en  in  1  command valid
- app_rdy  out  1  command accepted when app_en & app_rdy
- app_wdf_data  in  DATA_W  write data
- app_wdf_mask  in  DATA_W/8  byte mask, 1 = byte not written
- app_wdf_wren  in  1  write data valid
- app_wdf_end  in  1  last beat of write burst, always equals wren here
- app_wdf_rdy  out  1  write data accepted when app_wdf_wren & app_wdf_rdy
- app_rd_data  out  DATA_W  read data
- app_rd_data_valid  out  1  read data valid
- app_rd_data_end  out  1  last beat, equals app_rd_data_valid
- init_calib_complete  out  1  calibration done

## Operation
- Reset values: app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, init_calib_complete=0. Memory contents are not reset.
- Calibration state: a counter runs CALIB_CYCLES after reset release, then sets init_calib_complete=1, which stays set until reset. Both ready outputs stay 0 while calibrating.
- Word index = app_addr[3 +: MEM_WORDS_LOG2]. app_addr[2:0] and the bits above the index are ignored, so addresses wrap modulo the memory size.
- Write path: one pending-write-command register (index) and one write-data register (data, mask). Data may arrive before, with, or after its command.
  - The commit happens in the cycle both are held or arriving. Unmasked bytes are written and both registers are cleared.
  - app_rdy = calibrated & !pending_wr_cmd.
  - app_wdf_rdy = calibrated & !wdata_held.
- Read path: an accepted read samples memory at the accept edge and enters a RD_LATENCY-deep valid/data shift pipeline. There is no output backpressure, and one read can be accepted per cycle.
- Ordering: the write-commit to read-sample path is strictly in order. A read accepted while a write command is pending cannot occur because app_rdy=0.
- Reads to never-written words return X in simulation. Illegal app_cmd values are accepted and discarded.
- Reset mid-operation: all in-flight reads are dropped (valid=0 next cycle), pending write command and data are discarded, and calibration restarts.

## Timing
- Read accepted at edge T → app_rd_data_valid=app_rd_data_end=1 for exactly one cycle after edge T+RD_LATENCY. Back-to-back reads produce back-to-back valid beats.
- Write command and data accepted at the same edge T → memory updated at T, visible to a read accepted at T+1.
- Data accepted at T, command at T+k → commit at T+k. app_wdf_rdy=0 during (T, T+k].
- Command accepted at T, data at T+k → commit at T+k. app_rdy=0 during (T, T+k].
- init_calib_complete rises CALIB_CYCLES edges after rst deasserts. Ready outputs may assert the same cycle.

## Configuration
- MIG_UI_RESPONDER_STALL_EN defined: an 8-bit LFSR (seed 8'hA5, taps 8,6,5,4, advanced every cycle after calibration) forces app_rdy=0 and app_wdf_rdy=0 in cycles where its LSB=1. This exercises controller backpressure handling.
- Not defined: ready outputs follow only the rules above, and no LFSR is present.

## Structure
- Shared package mig_ui_pkg holds MIG_CMD_WRITE=3'b000, MIG_CMD_READ=3'b001, the DATA_W/ADDR_W defaults, and the LFSR seed. The same constants are used by the DDR controller.
- Sub-module mig_resp_rd_pipe: parameterised RD_LATENCY valid/data shift pipeline with asynchronous clear.
- Memory array, write-pairing registers, calibration counter and optional LFSR live in the top module.

## Test plan
- Reset release → init_calib_complete=0 for 63 cycles, 1 on cycle 64. app_rdy/app_wdf_rdy both 0 before that.
- Write data 128'h0123…CDEF with command at addr 27'h20 in the same cycle, then read at 27'h20 next cycle → valid 4 cycles later with identical data and app_rd_data_end=1.
- Data 128'hFFFF…FFFF with mask 16'h00FF at addr 0, command three cycles later → app_wdf_rdy=0 for those cycles. Readback of a word previously all-zero gives upper 8 bytes FF and lower 8 bytes 00.
- Write command at 27'h40 with data withheld → app_rdy=0 until data arrives, and a queued read is accepted only after the commit, returning the new data.
- Four back-to-back reads to 27'h00/08/10/18 → four consecutive valid beats in order. Address 27'h2000 aliases to word 0 with MEM_WORDS_LOG2=10.
- Reset asserted while two reads are in flight → no valid beats appear, and calibration restarts from zero.
